alu_seq: RTL

//   Parametrised, handshaked successor to the MCPU ALU. Single-cycle logic, arithmetic,

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand latches, alu_seq and the writeback mux.
// master drives operands and takes results; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: logic/arith/compare/shift ops; ALU_MULDIV_EN adds iterative MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle, or WIDTH+1 cycles for mul/div; result registered with its flags.
// Backpressure: in_ready only in IDLE; DONE holds result until out_ready, so 1 op per 2 cycles max.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_SLL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             ovf_q;
    logic             ill_q;

    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.res       = res_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;

    // Single-cycle datapath works straight off the inputs; its result is captured at accept.
    always_comb begin
        sh      = bus.b[SH_W-1:0];
        b_eff   = (bus.op == OP_SUB) ? (~bus.b + 1'b1) : bus.b;
        sum     = bus.a + b_eff;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SRL:  alu_res = bus.a >> sh;
            OP_SLL:  alu_res = bus.a << sh;
            OP_SRA:  alu_res = $signed(bus.a) >>> sh;
            // 11-14 only land here when the mul/div engine is absent; 15 is always reserved.
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   dv;
    logic [3:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   md_res;
    logic               is_md;
    logic               is_mul;

    assign is_md  = (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
    assign is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULHU);

    // acc = {high half, low half}: product/multiplier for mul, remainder/quotient for div.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv} : {(WIDTH+1){1'b0}});
        div_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_sh - {1'b0, dv};
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        case (op_q)
            OP_MUL:   md_res = acc_nxt[WIDTH-1:0];
            OP_MULHU: md_res = acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  md_res = (dv == '0) ? '1 : acc_nxt[WIDTH-1:0];
            // With a zero divisor the remainder shifts in the dividend unchanged.
            default:  md_res = acc_nxt[2*WIDTH-1:WIDTH];
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
            acc    <= '0;
            dv     <= '0;
            op_q   <= '0;
            cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
`ifdef ALU_MULDIV_EN
                        if (is_md) begin
                            state <= S_BUSY;
                            op_q  <= bus.op;
                            cnt   <= CNT_W'(WIDTH);
                            dv    <= is_mul ? bus.a : bus.b;
                            acc   <= {{WIDTH{1'b0}}, (is_mul ? bus.b : bus.a)};
                        end else
`endif
                        begin
                            state  <= S_DONE;
                            res_q  <= alu_res;
                            zero_q <= (alu_res == '0);
                            ovf_q  <= alu_ovf;
                            ill_q  <= alu_ill;
                        end
                    end
                end
                S_BUSY: begin
`ifdef ALU_MULDIV_EN
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_DONE;
                        res_q  <= md_res;
                        zero_q <= (md_res == '0);
                        ovf_q  <= 1'b0;
                        ill_q  <= 1'b0;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
